// File: rtl/input_cond_pkg.sv
// Shared constants and sizing helper for the input conditioner.
package input_cond_pkg;

    localparam int DEF_CHANNELS        = 6;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

    // Bits needed to hold values 0..value-1, never less than one bit so the
    // bypass configuration still has a legal (unused) counter vector.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    // Width of a debounce counter that must reach debounce_cycles.
    function automatic int cnt_width(input int debounce_cycles);
        return clog2_min1(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_cell.sv
// One channel: synchronizer chain, debounce counter, level register and
// registered rise/fall pulses.
module debounce_cell
    import input_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic data_in,
    input  logic sample_tick,
    output logic data_out,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_next;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   rise_q;
    logic                   fall_q;

    assign s      = sync_q[SYNC_STAGES-1];
    assign s_next = sync_q[SYNC_STAGES-2];

    // Synchronizer chain, free-running on every clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
        end
    end

    // Next level/count. In bypass the level register loads in parallel with
    // the last sync stage, so data_out equals s with no extra cycle.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (DEBOUNCE_CYCLES == 0) begin
            level_d = s_next;
        end else if (sample_tick) begin
            if (s == level_q) begin
                cnt_d = '0;
            end else if (int'(cnt_q) + 1 >= DEBOUNCE_CYCLES) begin
                level_d = s;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Level, counter and edge pulses registered together so a pulse lines
    // up with the first cycle the new level is visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= RESET_LEVEL;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    assign data_out = level_q;
    assign rise     = rise_q;
    assign fall     = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Synchronise and debounce CHANNELS independent asynchronous inputs.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int CHANNELS        = DEF_CHANNELS,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] data_in,
    input  logic                sample_tick,
    output logic [CHANNELS-1:0] data_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_cell #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL)
        ) u_cell (
            .clk         (clk),
            .reset_n     (reset_n),
            .data_in     (data_in[i]),
            .sample_tick (sample_tick),
            .data_out    (data_out[i]),
            .rise        (rise[i]),
            .fall        (fall[i])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: a debounced instance (4 samples) and a bypass
// instance (0) share stimulus and are checked against a behavioural model.
module tb_input_conditioner;

    localparam int CH   = 6;
    localparam int SYNC = 2;
    localparam int DEB [2] = '{4, 0};

    logic          clk;
    logic          reset_n;
    logic [CH-1:0] data_in;
    logic          sample_tick;
    logic [CH-1:0] out_a, rise_a, fall_a;
    logic [CH-1:0] out_b, rise_b, fall_b;

    int n_checks;
    int n_errors;

    // model state
    logic [CH-1:0] hist[$];
    logic [CH-1:0] exp_out  [2];
    logic [CH-1:0] exp_rise [2];
    logic [CH-1:0] exp_fall [2];
    int            exp_cnt  [2][CH];

    input_conditioner #(.CHANNELS(CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(4),
                        .RESET_LEVEL(1'b0)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .sample_tick(sample_tick),
        .data_out(out_a), .rise(rise_a), .fall(fall_a));

    input_conditioner #(.CHANNELS(CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(0),
                        .RESET_LEVEL(1'b0)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .sample_tick(sample_tick),
        .data_out(out_b), .rise(rise_b), .fall(fall_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < SYNC; k++) hist.push_back('0);
        for (int m = 0; m < 2; m++) begin
            exp_out[m]  = '0;
            exp_rise[m] = '0;
            exp_fall[m] = '0;
            for (int c = 0; c < CH; c++) exp_cnt[m][c] = 0;
        end
    endtask

    // Apply the debounce rules to what the inputs were at this clk edge.
    task automatic model_edge();
        logic [CH-1:0] s_old, s_new, prev;
        if (!reset_n) begin
            model_reset();
            return;
        end
        s_old = hist[SYNC-1];
        hist.push_front(data_in);
        void'(hist.pop_back());
        s_new = hist[SYNC-1];
        for (int m = 0; m < 2; m++) begin
            prev = exp_out[m];
            if (DEB[m] == 0) begin
                exp_out[m] = s_new;
            end else if (sample_tick) begin
                for (int c = 0; c < CH; c++) begin
                    if (s_old[c] == exp_out[m][c]) begin
                        exp_cnt[m][c] = 0;
                    end else begin
                        exp_cnt[m][c]++;
                        if (exp_cnt[m][c] == DEB[m]) begin
                            exp_out[m][c] = s_old[c];
                            exp_cnt[m][c] = 0;
                        end
                    end
                end
            end
            exp_rise[m] = exp_out[m] & ~prev;
            exp_fall[m] = ~exp_out[m] & prev;
        end
    endtask

    // One clk: let the edge happen, sample 1 time unit later, compare.
    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        chk("out_a",  32'(out_a),  32'(exp_out[0]));
        chk("rise_a", 32'(rise_a), 32'(exp_rise[0]));
        chk("fall_a", 32'(fall_a), 32'(exp_fall[0]));
        chk("out_b",  32'(out_b),  32'(exp_out[1]));
        chk("rise_b", 32'(rise_b), 32'(exp_rise[1]));
        chk("fall_b", 32'(fall_b), 32'(exp_fall[1]));
        chk("no_both_a", 32'(rise_a & fall_a), 32'(0));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int edge_seen;
        int rise_edges;
        logic [CH-1:0] any_pulse;
        int hold;

        n_checks    = 0;
        n_errors    = 0;
        reset_n     = 1'b0;
        data_in     = 6'h3F;
        sample_tick = 1'b1;
        model_reset();

        // reset / idle
        steps(3);
        reset_n = 1'b1;
        data_in = 6'h00;
        steps(6);

        // latency on channel 0 with per-clk sampling
        data_in    = 6'h01;
        edge_seen  = -1;
        rise_edges = 0;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (out_a[0] && edge_seen < 0) edge_seen = e;
            if (rise_a[0]) rise_edges++;
        end
        chk("latency_edge", 32'(edge_seen), 32'(6));
        chk("rise_count", 32'(rise_edges), 32'(1));
        data_in = 6'h00;
        steps(10);

        // glitch on channel 2 shorter than the debounce window
        any_pulse = '0;
        data_in   = 6'h04;
        for (int k = 0; k < 3; k++) begin
            step();
            any_pulse |= rise_a | fall_a;
        end
        data_in = 6'h00;
        for (int k = 0; k < 8; k++) begin
            step();
            any_pulse |= rise_a | fall_a;
        end
        chk("glitch_pulses", 32'(any_pulse), 32'(0));
        chk("glitch_level", 32'(out_a[2]), 32'(0));

        // sample_tick every 4th clk
        data_in = 6'h02;
        for (int k = 0; k < 40; k++) begin
            sample_tick = (k % 4 == 3);
            step();
        end
        chk("tick_rise_level", 32'(out_a[1]), 32'(1));
        data_in = 6'h00;
        for (int k = 0; k < 40; k++) begin
            sample_tick = (k % 4 == 3);
            step();
        end
        chk("tick_fall_level", 32'(out_a[1]), 32'(0));
        sample_tick = 1'b1;

        // multi-channel through the bypass instance
        data_in   = 6'h2A;
        edge_seen = -1;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (out_b == 6'h2A && edge_seen < 0) begin
                edge_seen = e;
                chk("bypass_rise", 32'(rise_b), 32'(6'h2A));
            end
        end
        chk("bypass_edge", 32'(edge_seen), 32'(2));
        data_in   = 6'h00;
        edge_seen = -1;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (fall_b == 6'h2A && edge_seen < 0) edge_seen = e;
        end
        chk("bypass_fall_edge", 32'(edge_seen), 32'(2));
        steps(8);

        // reset while channel 3 is mid-count (cnt = 2 after edge 4)
        data_in = 6'h08;
        steps(4);
        reset_n = 1'b0;
        step();
        chk("reset_mid_out", 32'(out_a), 32'(0));
        reset_n   = 1'b1;
        edge_seen = -1;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (out_a[3] && edge_seen < 0) edge_seen = e;
        end
        chk("reset_restart_edge", 32'(edge_seen), 32'(6));
        data_in = 6'h00;
        steps(8);

        // randomized: held levels, glitches, random ticks, rare resets
        hold = 0;
        for (int k = 0; k < 600; k++) begin
            if (hold == 0) begin
                data_in = CH'($urandom);
                hold    = $urandom_range(1, 10);
            end
            hold--;
            sample_tick = ($urandom_range(0, 3) != 0);
            reset_n     = ($urandom_range(0, 99) != 0);
            step();
        end
        reset_n = 1'b1;
        steps(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
